secp256k1_point_serializer: RTL and testbench

Output-side companion to the secp256k1 scalar multiplier. It captures an affine result point (x, y), or the point at infinity, and emits it as a SEC1-encoded big-endian byte stream over a valid/ready interface. The stream is either compressed (33 bytes) or uncompressed (65 bytes). The block sits between the multiplier's x_result/y_result outputs and any byte-wide transport (UART, AXI-Stream bridge, hash input).

---
 rtl/secp256k1_point_serializer.sv | 135 +++++++++++++
 tb/tb_secp256k1_point_serializer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/secp256k1_point_serializer.sv
// SEC1 byte-stream serializer for secp256k1 affine points.
// Emits 00 / 02|03+X / 04+X+Y big-endian over a valid/ready byte port.
module secp256k1_point_serializer #(
  parameter logic [255:0] P =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] x_in,
  input  logic [255:0] y_in,
  input  logic         is_inf,
  input  logic         compress,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last,
  output logic         busy,
  output logic         err_range
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PREFIX,
    S_XBYTES,
    S_YBYTES
  } state_t;

  state_t       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [255:0] x_q, y_q;
  logic         inf_q, cmp_q;
  logic         shift_x, shift_y;
  logic         last_byte;
  logic         range_bad;

  assign last_byte = (cnt_q == 6'd31);
  assign range_bad = (x_q >= P) || (y_q >= P);
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    err_range = 1'b0;
    shift_x   = 1'b0;
    shift_y   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (inf_q) begin
          state_d = S_PREFIX;
        end else if (CHECK_RANGE && range_bad) begin
          err_range = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_PREFIX;
        end
      end
      S_PREFIX: begin
        out_valid = 1'b1;
        out_last  = inf_q;
        if (inf_q)      out_data = 8'h00;
        else if (cmp_q) out_data = {7'h01, y_q[0]};
        else            out_data = 8'h04;
        if (out_ready) begin
          cnt_d   = 6'd0;
          state_d = inf_q ? S_IDLE : S_XBYTES;
        end
      end
      S_XBYTES: begin
        out_valid = 1'b1;
        out_data  = x_q[255:248];
        out_last  = cmp_q && last_byte;
        if (out_ready) begin
          shift_x = 1'b1;
          if (last_byte) begin
            cnt_d   = 6'd0;
            state_d = cmp_q ? S_IDLE : S_YBYTES;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_YBYTES: begin
        out_valid = 1'b1;
        out_data  = y_q[255:248];
        out_last  = last_byte;
        if (out_ready) begin
          shift_y = 1'b1;
          if (last_byte) begin
            cnt_d   = 6'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Coordinates shift out MSB-first; y stays intact until YBYTES for the parity bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      x_q     <= '0;
      y_q     <= '0;
      inf_q   <= 1'b0;
      cmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && in_valid) begin
        x_q   <= x_in;
        y_q   <= y_in;
        inf_q <= is_inf;
        cmp_q <= compress;
      end
      if (shift_x) x_q <= {x_q[247:0], 8'h00};
      if (shift_y) y_q <= {y_q[247:0], 8'h00};
    end
  end

endmodule

// File: tb/tb_secp256k1_point_serializer.sv
// Directed bench for secp256k1_point_serializer.
// Uses generator G, P-Gy, infinity, range reject, backpressure, reset.
module tb_secp256k1_point_serializer;

  localparam logic [255:0] P =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] GX =
    256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY =
    256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_valid_b = 1'b0;
  logic         is_inf = 1'b0;
  logic         compress = 1'b0;
  logic         out_ready = 1'b0;
  logic [255:0] x_in = '0;
  logic [255:0] y_in = '0;

  logic       ir_a, ov_a, ol_a, busy_a, er_a;
  logic [7:0] od_a;
  logic       ir_b, ov_b, ol_b, busy_b, er_b;
  logic [7:0] od_b;

  secp256k1_point_serializer dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(ir_a),
    .x_in(x_in), .y_in(y_in),
    .is_inf(is_inf), .compress(compress),
    .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .out_last(ol_a),
    .busy(busy_a), .err_range(er_a)
  );

  secp256k1_point_serializer #(.CHECK_RANGE(1'b0)) dut_nr (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_b), .in_ready(ir_b),
    .x_in(x_in), .y_in(y_in),
    .is_inf(is_inf), .compress(compress),
    .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .out_last(ol_b),
    .busy(busy_b), .err_range(er_b)
  );

  int vecs = 0;
  int errs = 0;
  int acc_a = 0;
  int rng_a = 0;
  logic [7:0] exp_b [65];
  int exp_n = 0;
  bit sel = 1'b0;

  logic       m_valid, m_last, m_busy, m_ir;
  logic [7:0] m_data;
  always_comb begin
    m_valid = sel ? ov_b : ov_a;
    m_last  = sel ? ol_b : ol_a;
    m_data  = sel ? od_b : od_a;
    m_busy  = sel ? busy_b : busy_a;
    m_ir    = sel ? ir_b : ir_a;
  end

  always @(posedge clk) begin
    if (in_valid && ir_a) acc_a <= acc_a + 1;
    if (er_a) rng_a <= rng_a + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic build(input logic [7:0] pfx, input logic [255:0] x,
                       input logic [255:0] y, input int n);
    logic [255:0] xs;
    logic [255:0] ys;
    xs = x;
    ys = y;
    exp_b[0] = pfx;
    for (int i = 0; i < 32; i++) begin
      exp_b[1+i]  = xs[255:248];
      exp_b[33+i] = ys[255:248];
      xs = xs << 8;
      ys = ys << 8;
    end
    exp_n = n;
  endtask

  // Called and returns at a falling edge; returns in the CHECK cycle
  task automatic send(input bit b, input logic [255:0] x,
                      input logic [255:0] y, input bit inf, input bit cmp);
    bit ok;
    ok = 1'b0;
    x_in = x;
    y_in = y;
    is_inf = inf;
    compress = cmp;
    if (b) in_valid_b = 1'b1;
    else   in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (b ? ir_b : ir_a) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_valid_b = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic rx(input bit bp, input int stop_at);
    int idx;
    bit done;
    bit hold;
    bit r;
    logic [9:0] hv;
    idx = 0;
    done = 1'b0;
    hold = 1'b0;
    hv = '0;
    for (int c = 0; c < 4000 && !done; c++) begin
      r = bp ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (hold) chk("hold_stable", {m_valid, m_last, m_data}, hv);
      hold = 1'b0;
      out_ready = r;
      if (m_valid && r) begin
        if (idx < 65) begin
          chk($sformatf("byte%0d", idx), m_data, exp_b[idx]);
          chk($sformatf("last%0d", idx), m_last, idx == exp_n - 1);
        end else begin
          chk("overrun", idx, exp_n);
          done = 1'b1;
        end
        idx++;
        if (m_last || idx == stop_at) done = 1'b1;
      end else if (m_valid) begin
        hold = 1'b1;
        hv = {m_valid, m_last, m_data};
      end else if (idx > 0) begin
        chk("valid_drop", m_valid, 1);
      end
      @(negedge clk);
    end
    if (!done) chk("rx_timeout", 0, 1);
    if (stop_at == 0) begin
      chk("byte_count", idx, exp_n);
      chk("end_valid", m_valid, 0);
      chk("end_in_ready", m_ir, 1);
      chk("end_busy", m_busy, 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, ir_a, 1);
    chk({tag, "_out_valid"}, ov_a, 0);
    chk({tag, "_out_data"}, od_a, 0);
    chk({tag, "_out_last"}, ol_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_err"}, er_a, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int a0;
    int r0;
    out_ready = 1'b1;
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    build(8'h02, GX, GY, 33);
    send(0, GX, GY, 1'b0, 1'b1);
    chk("lat_check_valid", ov_a, 0);
    chk("lat_check_busy", busy_a, 1);
    @(negedge clk);
    chk("lat_prefix_valid", ov_a, 1);
    rx(0, 0);

    build(8'h04, GX, GY, 65);
    send(0, GX, GY, 1'b0, 1'b0);
    rx(0, 0);

    build(8'h03, GX, P - GY, 33);
    send(0, GX, P - GY, 1'b0, 1'b1);
    rx(0, 0);

    build(8'h00, GX, GY, 1);
    send(0, 256'h1234, 256'h5678, 1'b1, 1'b0);
    rx(0, 0);

    r0 = rng_a;
    send(0, P, GY, 1'b0, 1'b1);
    chk("rng_err_hi", er_a, 1);
    chk("rng_valid0", ov_a, 0);
    chk("rng_busy", busy_a, 1);
    @(negedge clk);
    chk("rng_err_lo", er_a, 0);
    chk("rng_valid1", ov_a, 0);
    chk("rng_in_ready", ir_a, 1);
    chk("rng_busy_lo", busy_a, 0);
    @(negedge clk);
    chk("rng_pulses", rng_a - r0, 1);
    chk("rng_valid2", ov_a, 0);

    sel = 1'b1;
    build(8'h02, P, GY, 33);
    send(1, P, GY, 1'b0, 1'b1);
    rx(0, 0);
    sel = 1'b0;

    build(8'h02, GX, GY, 33);
    a0 = acc_a;
    send(0, GX, GY, 1'b0, 1'b1);
    x_in = '0;
    y_in = '0;
    is_inf = 1'b1;
    compress = 1'b0;
    in_valid = 1'b1;
    rx(1, 0);
    chk("no_overwrite", acc_a - a0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("queued_accept", acc_a - a0, 2);
    build(8'h00, GX, GY, 1);
    rx(1, 0);
    out_ready = 1'b1;

    build(8'h04, GX, GY, 65);
    send(0, GX, GY, 1'b0, 1'b0);
    rx(0, 10);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ir_a, 1);
    build(8'h02, GX, GY, 33);
    send(0, GX, GY, 1'b0, 1'b1);
    rx(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
